// File: rtl/dmem_responder.sv
// Data-memory responder for a small CPU: word RAM, LED register, free-running
// cycle counter and a console TX FIFO, all decoded from one memory-stage port.
module dmem_responder #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        mem_write,
  output logic [31:0] rdata_out,
  output logic [15:0] led_out,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [29:0] WA_LED    = 30'h3FFF_C000;
  localparam logic [29:0] WA_CYCLE  = 30'h3FFF_C001;
  localparam logic [29:0] WA_TXDATA = 30'h3FFF_C002;
  localparam logic [29:0] WA_STATUS = 30'h3FFF_C003;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   r_ram [RAM_WORDS];
  logic [15:0]   r_led;
  logic [31:0]   r_cycle;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_head;
  logic          r_overflow;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [29:0]   w_word_addr;
  logic          w_sel_ram;
  logic          w_sel_led;
  logic          w_sel_cycle;
  logic          w_sel_tx;
  logic          w_sel_status;
  logic [AW-1:0] w_ram_idx;
  logic          w_unused_ok;

  assign w_word_addr  = addr_in[31:2];
  assign w_sel_ram    = (addr_in[31:AW+2] == '0);
  assign w_sel_led    = (w_word_addr == WA_LED);
  assign w_sel_cycle  = (w_word_addr == WA_CYCLE);
  assign w_sel_tx     = (w_word_addr == WA_TXDATA);
  assign w_sel_status = (w_word_addr == WA_STATUS);
  assign w_ram_idx    = addr_in[AW+1:2];
  // Byte offset is irrelevant: only whole-word accesses exist.
  assign w_unused_ok  = &{1'b0, addr_in[1:0]};

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [PW-1:0] w_wr_ptr_next;
  logic [PW-1:0] w_rd_ptr_next;
  logic [CW-1:0] w_count_next;
  logic [7:0]    w_head_next;
  logic [31:0]   w_count_ext;
  logic [2:0]    w_count_field;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = con_valid && con_ready;
  assign w_push_req = mem_write && w_sel_tx;
  // A simultaneous pop frees a slot, so a push at full is still accepted.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = mem_write && w_sel_status;

  always_comb begin
    w_wr_ptr_next = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_rd_ptr_next = w_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_count_next  = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
    // The head register preloads whichever entry will sit at the read pointer;
    // if that slot is being written this edge the new byte is taken directly.
    w_head_next = r_head;
    if (w_count_next != '0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
        w_head_next = wdata_in[7:0];
      end else begin
        w_head_next = r_fifo[w_rd_ptr_next];
      end
    end
  end

  assign w_count_ext   = 32'(r_count);
  assign w_count_field = (w_count_ext > 32'd7) ? 3'd7 : w_count_ext[2:0];

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_write && w_sel_ram) begin
      r_ram[w_ram_idx] <= wdata_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= wdata_in[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led      <= '0;
      r_cycle    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_cycle  <= r_cycle + 32'd1;
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
      if (mem_write && w_sel_led) begin
        r_led <= wdata_in[15:0];
      end
      // Clear takes priority over a same-edge overflow event.
      if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end else if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign led_out   = r_led;
  assign con_valid = !w_empty;
  assign con_data  = r_head;

  always_comb begin
    rdata_out = '0;
    if (w_sel_ram) begin
      rdata_out = r_ram[w_ram_idx];
    end else if (w_sel_led) begin
      rdata_out = {16'b0, r_led};
    end else if (w_sel_cycle) begin
      rdata_out = r_cycle;
    end else if (w_sel_status) begin
      rdata_out = {26'b0, r_overflow, w_count_field, w_empty, w_full};
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_dmem_responder;

  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;
  localparam logic [31:0] A_UNMAP  = 32'hFFFF_0100;

  localparam int K_RDATA = 0;
  localparam int K_LED   = 1;
  localparam int K_CVAL  = 2;
  localparam int K_CDATA = 3;

  logic        clk;
  logic        rst;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        mem_write;
  logic [31:0] rdata_out;
  logic [15:0] led_out;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  dmem_responder #(.RAM_WORDS(256), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .mem_write (mem_write),
    .rdata_out (rdata_out),
    .led_out   (led_out),
    .con_valid (con_valid),
    .con_data  (con_data),
    .con_ready (con_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    logic [31:0] addr;
  } chk_t;

  chk_t        chk_q[$];
  logic [7:0]  con_q[$];
  int          chk_n = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic string kname(input int k);
    case (k)
      K_RDATA: return "rdata";
      K_LED:   return "led_out";
      K_CVAL:  return "con_valid";
      default: return "con_data";
    endcase
  endfunction

  // Monitor: checks requested this cycle, plus every console handshake.
  chk_t        m_e;
  logic [31:0] m_act;
  logic [7:0]  m_byte;
  always @(negedge clk) begin
    for (int i = 0; i < chk_n; i++) begin
      tests++;
      if (chk_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL scoreboard_empty actual=none required=entry");
      end else begin
        m_e = chk_q.pop_front();
        case (m_e.kind)
          K_RDATA: m_act = rdata_out;
          K_LED:   m_act = {16'b0, led_out};
          K_CVAL:  m_act = {31'b0, con_valid};
          default: m_act = {24'b0, con_data};
        endcase
        if (m_act !== m_e.exp) begin
          fails++;
          $display("[TB] FAIL %s addr=%h actual=%h required=%h", kname(m_e.kind), m_e.addr, m_act, m_e.exp);
        end else begin
          $display("[TB] ok   %s addr=%h value=%h", kname(m_e.kind), m_e.addr, m_act);
        end
      end
    end
    if (!rst && con_valid && con_ready) begin
      tests++;
      if (con_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL con_pop_unexpected actual=%h required=none", con_data);
      end else begin
        m_byte = con_q.pop_front();
        if (con_data !== m_byte) begin
          fails++;
          $display("[TB] FAIL con_pop actual=%h required=%h", con_data, m_byte);
        end else begin
          $display("[TB] ok   con_pop byte=%h", con_data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk_n = 0;
  endtask

  task automatic chk(input int kind, input logic [31:0] exp);
    chk_t e;
    e.kind = kind;
    e.exp  = exp;
    e.addr = addr_in;
    chk_q.push_back(e);
    chk_n++;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    addr_in   = a;
    wdata_in  = d;
    mem_write = 1'b1;
    step();
    mem_write = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] exp);
    addr_in   = a;
    mem_write = 1'b0;
    chk(K_RDATA, exp);
    step();
  endtask

  initial begin
    rst       = 1'b1;
    addr_in   = '0;
    wdata_in  = '0;
    mem_write = 1'b0;
    con_ready = 1'b0;
    step();
    step();
    chk(K_LED, 32'h0);
    chk(K_CVAL, 32'h0);
    chk(K_CDATA, 32'h0);
    step();

    rst = 1'b0;
    ld(A_CYCLE, 32'd0);
    ld(A_CYCLE, 32'd1);
    ld(A_CYCLE, 32'd2);
    ld(A_STATUS, 32'h02);

    // RAM round trip
    st(32'h14, 32'h1111_1111);
    st(32'h10, 32'hDEAD_BEEF);
    ld(32'h10, 32'hDEAD_BEEF);
    ld(32'h13, 32'hDEAD_BEEF);
    ld(32'h14, 32'h1111_1111);

    // LED and unmapped
    st(A_LED, 32'h1234_ABCD);
    chk(K_LED, 32'h0000_ABCD);
    ld(A_LED, 32'h0000_ABCD);
    st(A_UNMAP, 32'hFFFF_FFFF);
    ld(A_UNMAP, 32'h0);
    chk(K_LED, 32'h0000_ABCD);
    ld(A_TXDATA, 32'h0);

    // FIFO fill, overflow, drain
    con_ready = 1'b0;
    for (int b = 8'h41; b <= 8'h44; b++) begin
      st(A_TXDATA, 32'(b));
      con_q.push_back(8'(b));
    end
    chk(K_CVAL, 32'h1);
    chk(K_CDATA, 32'h41);
    ld(A_STATUS, 32'h11);
    st(A_TXDATA, 32'h45);
    ld(A_STATUS, 32'h31);
    con_ready = 1'b1;
    repeat (4) step();
    chk(K_CVAL, 32'h0);
    chk(K_CDATA, 32'h44);
    ld(A_STATUS, 32'h22);

    // Overflow clear
    con_ready = 1'b0;
    st(A_STATUS, 32'hFFFF_FFFF);
    ld(A_STATUS, 32'h02);

    // Push into empty: valid appears one cycle later
    chk(K_CVAL, 32'h0);
    st(A_TXDATA, 32'h66);
    con_q.push_back(8'h66);
    chk(K_CVAL, 32'h1);
    chk(K_CDATA, 32'h66);
    con_ready = 1'b1;
    step();
    con_ready = 1'b0;

    // Simultaneous push and pop at full
    for (int b = 8'h51; b <= 8'h54; b++) begin
      st(A_TXDATA, 32'(b));
      con_q.push_back(8'(b));
    end
    ld(A_STATUS, 32'h11);
    con_q.push_back(8'h55);
    addr_in   = A_TXDATA;
    wdata_in  = 32'h55;
    mem_write = 1'b1;
    con_ready = 1'b1;
    step();
    mem_write = 1'b0;
    con_ready = 1'b0;
    ld(A_STATUS, 32'h11);
    st(A_TXDATA, 32'h99);
    ld(A_STATUS, 32'h31);
    st(A_STATUS, 32'h0);
    ld(A_STATUS, 32'h11);
    con_ready = 1'b1;
    repeat (4) step();
    con_ready = 1'b0;
    chk(K_CVAL, 32'h0);
    ld(A_STATUS, 32'h02);

    // Reset mid-operation
    st(32'h20, 32'hCAFE_F00D);
    st(A_TXDATA, 32'h71);
    st(A_TXDATA, 32'h72);
    st(A_TXDATA, 32'h73);
    ld(A_STATUS, 32'h0C);
    rst = 1'b1;
    chk(K_CVAL, 32'h0);
    chk(K_CDATA, 32'h0);
    chk(K_LED, 32'h0);
    step();
    step();
    rst = 1'b0;
    ld(A_CYCLE, 32'd0);
    ld(A_CYCLE, 32'd1);
    ld(A_STATUS, 32'h02);
    ld(32'h20, 32'hCAFE_F00D);
    ld(32'h10, 32'hDEAD_BEEF);
    step();

    tests++;
    if (con_q.size() != 0 || chk_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL leftover_expected actual=%0d required=0", con_q.size() + chk_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    tests++;
    fails++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
